// File: rtl/scc_run_ctrl.sv
// Run controller for one or more SCC cores: reset sequencing, clock enables, cycle budget, halt/error status.
// Optional feature macro: SCC_RUN_CTRL_ERR_STOP_EN (a core error ends the run).
module scc_run_ctrl #(
  parameter int NUM_CORES  = 1,
  parameter int ERR_W      = 2,
  parameter int CYC_W      = 32,
  parameter int RST_CYCLES = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [CYC_W-1:0]           cycle_limit_i,
  input  logic [NUM_CORES-1:0]       halt_f_i,
  input  logic [NUM_CORES*ERR_W-1:0] err_bits_i,
  output logic                       core_rst_o,
  output logic [NUM_CORES-1:0]       core_clk_en_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       timeout_o,
  output logic                       err_stop_o,
  output logic [NUM_CORES-1:0]       halt_mask_o,
  output logic [NUM_CORES*ERR_W-1:0] err_latched_o,
  output logic [CYC_W-1:0]           cycle_count_o
);

  localparam int RC_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES);
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic [RC_W-1:0]            rst_cnt_q, rst_cnt_d;
  logic [CYC_W-1:0]           limit_q, limit_d;
  logic                       core_rst_q, core_rst_d;
  logic [NUM_CORES-1:0]       core_clk_en_q, core_clk_en_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       timeout_q, timeout_d;
  logic                       err_stop_q, err_stop_d;
  logic [NUM_CORES-1:0]       halt_mask_q, halt_mask_d;
  logic [NUM_CORES*ERR_W-1:0] err_latched_q, err_latched_d;
  logic [CYC_W-1:0]           cycle_count_q, cycle_count_d;

  logic                       all_halted_s;
  logic                       limit_hit_s;
  logic                       err_hit_s;
  logic [NUM_CORES-1:0]       halt_next_s;

  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    if (v == {CYC_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CYC_W-1){1'b0}}, 1'b1};
    end
  endfunction

`ifdef SCC_RUN_CTRL_ERR_STOP_EN
  assign err_hit_s = |err_bits_i;
`else
  assign err_hit_s = 1'b0;
`endif

  // Exit conditions only look at registered status, so each ends the run one edge after it is recorded.
  assign all_halted_s = &halt_mask_q;
  assign limit_hit_s  = (limit_q != {CYC_W{1'b0}}) && (cycle_count_q == limit_q);
  assign halt_next_s  = halt_mask_q | halt_f_i;

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    limit_d       = limit_q;
    core_rst_d    = core_rst_q;
    core_clk_en_d = core_clk_en_q;
    busy_d        = busy_q;
    done_d        = done_q;
    timeout_d     = timeout_q;
    err_stop_d    = err_stop_q;
    halt_mask_d   = halt_mask_q;
    err_latched_d = err_latched_q;
    cycle_count_d = cycle_count_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d       = ST_RESET;
          rst_cnt_d     = RC_LOAD;
          limit_d       = cycle_limit_i;
          core_rst_d    = 1'b1;
          core_clk_en_d = {NUM_CORES{1'b1}};
          busy_d        = 1'b1;
          done_d        = 1'b0;
          timeout_d     = 1'b0;
          err_stop_d    = 1'b0;
          halt_mask_d   = {NUM_CORES{1'b0}};
          err_latched_d = {(NUM_CORES*ERR_W){1'b0}};
          cycle_count_d = {CYC_W{1'b0}};
        end else begin
          state_d = state_q;
        end
      end

      ST_RESET: begin
        if (rst_cnt_q == {RC_W{1'b0}}) begin
          state_d    = ST_RUN;
          core_rst_d = 1'b0;
        end else begin
          rst_cnt_d = rst_cnt_q - {{(RC_W-1){1'b0}}, 1'b1};
        end
      end

      ST_RUN: begin
        if (err_stop_q || all_halted_s || limit_hit_s) begin
          state_d       = ST_DONE;
          core_rst_d    = 1'b0;
          core_clk_en_d = {NUM_CORES{1'b0}};
          busy_d        = 1'b0;
          done_d        = 1'b1;
          // Priority: error, then halt, then budget.
          timeout_d     = !err_stop_q && !all_halted_s;
        end else begin
          halt_mask_d   = halt_next_s;
          err_latched_d = err_latched_q | err_bits_i;
          cycle_count_d = sat_inc(cycle_count_q);
          if (err_hit_s) begin
            err_stop_d    = 1'b1;
            core_clk_en_d = {NUM_CORES{1'b0}};
          end else begin
            core_clk_en_d = ~halt_next_s;
          end
        end
      end

      default: begin
        state_d       = ST_IDLE;
        core_rst_d    = 1'b1;
        core_clk_en_d = {NUM_CORES{1'b0}};
        busy_d        = 1'b0;
        done_d        = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      rst_cnt_q     <= {RC_W{1'b0}};
      limit_q       <= {CYC_W{1'b0}};
      core_rst_q    <= 1'b1;
      core_clk_en_q <= {NUM_CORES{1'b0}};
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      err_stop_q    <= 1'b0;
      halt_mask_q   <= {NUM_CORES{1'b0}};
      err_latched_q <= {(NUM_CORES*ERR_W){1'b0}};
      cycle_count_q <= {CYC_W{1'b0}};
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      limit_q       <= limit_d;
      core_rst_q    <= core_rst_d;
      core_clk_en_q <= core_clk_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      err_stop_q    <= err_stop_d;
      halt_mask_q   <= halt_mask_d;
      err_latched_q <= err_latched_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign core_rst_o    = core_rst_q;
  assign core_clk_en_o = core_clk_en_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign timeout_o     = timeout_q;
  assign err_stop_o    = err_stop_q;
  assign halt_mask_o   = halt_mask_q;
  assign err_latched_o = err_latched_q;
  assign cycle_count_o = cycle_count_q;

endmodule

// File: tb/tb_scc_run_ctrl.sv
// Directed bench for scc_run_ctrl: a 2-core instance (32-bit counter) and a 1-core instance (5-bit counter).
module tb_scc_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        start2;
  logic [31:0] lim2;
  logic [1:0]  halt2;
  logic [3:0]  err2;
  logic        core_rst2, busy2, done2, to2, es2;
  logic [1:0]  en2, mask2;
  logic [3:0]  errl2;
  logic [31:0] cnt2;

  logic        start1;
  logic [4:0]  lim1;
  logic [0:0]  halt1;
  logic [1:0]  err1;
  logic        core_rst1, busy1, done1, to1, es1;
  logic [0:0]  en1, mask1;
  logic [1:0]  errl1;
  logic [4:0]  cnt1;

  logic [1:0]  exp_mask;

  int n_chk  = 0;
  int n_pass = 0;

  scc_run_ctrl #(.NUM_CORES(2), .ERR_W(2), .CYC_W(32), .RST_CYCLES(3)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .cycle_limit_i(lim2),
    .halt_f_i(halt2), .err_bits_i(err2), .core_rst_o(core_rst2),
    .core_clk_en_o(en2), .busy_o(busy2), .done_o(done2), .timeout_o(to2),
    .err_stop_o(es2), .halt_mask_o(mask2), .err_latched_o(errl2),
    .cycle_count_o(cnt2)
  );

  scc_run_ctrl #(.NUM_CORES(1), .ERR_W(2), .CYC_W(5), .RST_CYCLES(3)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .cycle_limit_i(lim1),
    .halt_f_i(halt1), .err_bits_i(err1), .core_rst_o(core_rst1),
    .core_clk_en_o(en1), .busy_o(busy1), .done_o(done1), .timeout_o(to1),
    .err_stop_o(es1), .halt_mask_o(mask1), .err_latched_o(errl1),
    .cycle_count_o(cnt1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Starts a run and checks the clear, the busy rise and the 3-cycle core reset window.
  task automatic begin_run(input bit d1, input logic [31:0] lim);
    if (d1) begin
      start1 = 1'b1;
      lim1   = lim[4:0];
    end else begin
      start2 = 1'b1;
      lim2   = lim;
    end
    tick();
    start1 = 1'b0;
    start2 = 1'b0;
    if (d1) begin
      chk("start1_busy",  64'(busy1), 64'd1);
      chk("start1_crst",  64'(core_rst1), 64'd1);
      chk("start1_en",    64'(en1), 64'd1);
      chk("start1_done",  64'(done1), 64'd0);
      chk("start1_clear", 64'({to1, mask1, errl1, cnt1}), 64'd0);
    end else begin
      chk("start2_busy",  64'(busy2), 64'd1);
      chk("start2_crst",  64'(core_rst2), 64'd1);
      chk("start2_en",    64'(en2), 64'd3);
      chk("start2_done",  64'(done2), 64'd0);
      chk("start2_clear", 64'({to2, es2, mask2, errl2, cnt2}), 64'd0);
    end
    ticks(2);
    chk("rst_hold", 64'(d1 ? core_rst1 : core_rst2), 64'd1);
    tick();
    chk("rst_fall", 64'(d1 ? core_rst1 : core_rst2), 64'd0);
    chk("run_busy", 64'(d1 ? busy1 : busy2), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    start1 = 1'b0; lim1 = 5'd0; halt1 = 1'b0; err1 = 2'b00;
    start2 = 1'b0; lim2 = 32'd0; halt2 = 2'b00; err2 = 4'b0000;
    ticks(2);
    chk("por_crst2", 64'(core_rst2), 64'd1);
    chk("por_out2",  64'({en2, busy2, done2, to2, es2, mask2, errl2, cnt2}), 64'd0);
    chk("por_crst1", 64'(core_rst1), 64'd1);
    chk("por_out1",  64'({en1, busy1, done1, to1, es1, mask1, errl1, cnt1}), 64'd0);
    #2 rst = 1'b0;
    tick();
    chk("idle_hold", 64'({core_rst2, busy2}), 64'd2);

    // 1 core, unlimited, halt on RUN cycle 20.
    begin_run(1'b1, 32'd0);
    ticks(19);
    halt1 = 1'b1;
    tick();
    halt1 = 1'b0;
    chk("t1_cnt20", 64'(cnt1), 64'd20);
    chk("t1_mask",  64'({mask1, en1}), 64'b10);
    tick();
    chk("t1_done",  64'({done1, busy1, to1, core_rst1, en1}), 64'b10000);
    chk("t1_final", 64'({mask1, cnt1}), 64'({1'b1, 5'd20}));

    // 2 cores, limit 50, no halts; start mid-run must be ignored.
    begin_run(1'b0, 32'd50);
    ticks(19);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("t2_start_ign", 64'({busy2, core_rst2, cnt2}), 64'({1'b1, 1'b0, 32'd20}));
    ticks(30);
    chk("t2_cnt50", 64'({done2, cnt2}), 64'({1'b0, 32'd50}));
    tick();
    chk("t2_done", 64'({done2, to2, busy2, en2, mask2}), 64'b1100000);
    chk("t2_cnt",  64'(cnt2), 64'd50);
    tick();
    chk("t2_hold", 64'({done2, to2, cnt2}), 64'({1'b1, 1'b1, 32'd50}));

    // Staggered halts: core0 at cycle 5, core1 at cycle 9.
    begin_run(1'b0, 32'd0);
    ticks(4);
    halt2 = 2'b01;
    tick();
    halt2 = 2'b00;
    chk("t3_en_c5", 64'({en2, mask2}), 64'b1001);
    ticks(3);
    chk("t3_en_c8", 64'({en2, done2}), 64'b100);
    halt2 = 2'b10;
    tick();
    halt2 = 2'b00;
    chk("t3_c9", 64'({en2, mask2, done2, cnt2}), 64'({2'b00, 2'b11, 1'b0, 32'd9}));
    tick();
    chk("t3_done", 64'({done2, to2, cnt2}), 64'({1'b1, 1'b0, 32'd9}));

    // Last halt and budget together: halt wins.
    begin_run(1'b0, 32'd10);
    ticks(9);
    halt2 = 2'b11;
    tick();
    halt2 = 2'b00;
    chk("t4_c10", 64'({mask2, cnt2}), 64'({2'b11, 32'd10}));
    tick();
    chk("t4_done", 64'({done2, to2}), 64'b10);

    // Error pulse on core0 at cycle 4.
    begin_run(1'b0, 32'd0);
    ticks(3);
    err2 = 4'b0001;
    tick();
    err2 = 4'b0000;
    chk("t5_errl", 64'(errl2), 64'd1);
`ifdef SCC_RUN_CTRL_ERR_STOP_EN
    chk("t5_es", 64'(es2), 64'd1);
    tick();
    chk("t5_done", 64'({done2, es2, to2, en2, cnt2}), 64'({1'b1, 1'b1, 1'b0, 2'b00, 32'd4}));
    exp_mask = 2'b00;
`else
    chk("t5_es", 64'({es2, busy2}), 64'b01);
    ticks(3);
    halt2 = 2'b11;
    tick();
    halt2 = 2'b00;
    tick();
    chk("t5_done", 64'({done2, es2, to2, errl2, cnt2}), 64'({1'b1, 1'b0, 1'b0, 4'b0001, 32'd8}));
    exp_mask = 2'b11;
`endif
    // Halt and error inputs are ignored in DONE.
    halt2 = 2'b11;
    err2  = 4'b1111;
    tick();
    halt2 = 2'b00;
    err2  = 4'b0000;
    chk("t5_ign", 64'({mask2, errl2}), 64'({exp_mask, 4'b0001}));

    // Asynchronous reset mid-RUN, then a clean rerun.
    begin_run(1'b0, 32'd0);
    ticks(7);
    chk("t6_c7", 64'(cnt2), 64'd7);
    #2 rst = 1'b1;
    #1;
    chk("t6_arst_crst", 64'(core_rst2), 64'd1);
    chk("t6_arst_out",  64'({en2, busy2, done2, to2, es2, mask2, errl2, cnt2}), 64'd0);
    #2 rst = 1'b0;
    tick();
    begin_run(1'b0, 32'd5);
    ticks(5);
    tick();
    chk("t6_rerun", 64'({done2, to2, cnt2}), 64'({1'b1, 1'b1, 32'd5}));

    // 5-bit counter saturates with unlimited budget.
    begin_run(1'b1, 32'd0);
    ticks(40);
    chk("t7_sat", 64'({busy1, cnt1}), 64'({1'b1, 5'd31}));
    halt1 = 1'b1;
    tick();
    halt1 = 1'b0;
    tick();
    chk("t7_done", 64'({done1, to1, cnt1}), 64'({1'b1, 1'b0, 5'd31}));

    // Budget equal to the counter maximum.
    begin_run(1'b1, 32'd31);
    ticks(31);
    chk("t8_c31", 64'({done1, cnt1}), 64'({1'b0, 5'd31}));
    tick();
    chk("t8_done", 64'({done1, to1}), 64'b11);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/scc_run_ctrl.md
# scc_run_ctrl

Parametrised hardware run controller for one or more SCC cores. It sequences core reset and clock enable and counts run cycles. It stops each core on `halt_f` and enforces a cycle budget (watchdog). It also latches error bits and reports per-core completion. It sits between the top-level harness and the `scc_f25_top` instances, replacing fixed-length reset/run sequencing with a programmable, multi-core one.

## Interface
- `NUM_CORES`, 1, number of controlled cores (1–8)
- `ERR_W`, 2, width of each core's `err_bits`
- `CYC_W`, 32, width of cycle counter and limit
- `RST_CYCLES`, 3, cycles `core_rst` is held after `start` (≥1)

- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a run; sampled in IDLE/DONE only
- `cycle_limit`  in  CYC_W  run budget in RUN cycles; 0 = unlimited; captured on `start`
- `halt_f`  in  NUM_CORES  per-core halt flag
- `err_bits`  in  NUM_CORES*ERR_W  per-core error bits, core i at [i*ERR_W +: ERR_W]
- `core_rst`  out  1  reset to all cores
- `core_clk_en`  out  NUM_CORES  per-core clock enable
- `busy`  out  1  high in RESET or RUN
- `done`  out  1  high in DONE
- `timeout`  out  1  run ended on cycle budget
- `err_stop`  out  1  run ended on error (macro only; else tied 0)
- `halt_mask`  out  NUM_CORES  cores that have halted this run
- `err_latched`  out  NUM_CORES*ERR_W  sticky OR of `err_bits` during RUN
- `cycle_count`  out  CYC_W  RUN cycles elapsed, saturating

## Operation
- States: IDLE, RESET, RUN, DONE.
- IDLE: `core_rst`=1, `core_clk_en`=0. `start` → RESET. On entry from `start`, clear `halt_mask`, `err_latched`, `cycle_count`, `timeout` and `err_stop`, and capture `cycle_limit`.
- RESET: `core_rst`=1 and `core_clk_en`=all ones, held for exactly RST_CYCLES cycles, then → RUN. `start` is ignored.
- RUN: `core_rst`=0. `core_clk_en[i]` = ~`halt_mask[i]`. Each cycle:
  - `cycle_count` increments, saturating at all ones.
  - `halt_mask` |= `halt_f`.
  - `err_latched` |= `err_bits`.
- RUN exit, evaluated on registered values:
  - All `halt_mask` bits set → DONE, `timeout`=0.
  - Otherwise, if limit ≠ 0 and `cycle_count` == limit → DONE, `timeout`=1.
- DONE: `core_rst`=0, `core_clk_en`=0. All status is held. `start` → RESET with a fresh clear, identical to the IDLE path.
- `start` is ignored in RESET and RUN.
- Simultaneous events: if the last core halts in the same cycle the limit is reached, halt wins (`timeout`=0). With the macro defined, error has priority over both.
- A `halt_f` that is already high in the first RUN cycle counts; that core runs for 0 further enabled cycles after the mask update.
- `halt_f` and `err_bits` are ignored outside RUN.

## Timing
- Reset values: state IDLE, `core_rst`=1, `core_clk_en`=0, `busy`=0, `done`=0, `timeout`=0, `err_stop`=0, `halt_mask`=0, `err_latched`=0, `cycle_count`=0.
- All outputs are registered.
- `start` high at edge N → `busy`=1 after edge N. `core_rst` falls after edge N+RST_CYCLES.
- `halt_f[i]` high at edge M in RUN → `halt_mask[i]`=1 and `core_clk_en[i]`=0 after edge M.
- Budget L: after L RUN cycles `cycle_count`=L. DONE is visible one edge later.
- An asserted `rst` at any point, including mid-RUN, forces the reset values immediately (asynchronous). Deassertion is synchronised by the harness.

## Configuration
- `SCC_RUN_CTRL_ERR_STOP_EN` defined:
  - A nonzero `err_bits` for any core in RUN latches into `err_latched` and sets `err_stop`=1.
  - The controller moves to DONE on the next edge, with `core_clk_en`=0 for all cores.
- Undefined: errors are only latched. `err_stop` is a constant 0 and the run continues.

## Test plan
- NUM_CORES=1, RST_CYCLES=3, limit=0, `start` pulse, `halt_f` rises after 20 RUN cycles → `core_rst` held 3 cycles, DONE with `cycle_count`=20, `timeout`=0, `halt_mask`=1.
- NUM_CORES=2, limit=50, no halts → DONE with `timeout`=1, `cycle_count`=50, `halt_mask`=0.
- NUM_CORES=2, core0 halts at cycle 5, core1 at cycle 9 → `core_clk_en`=2'b10 from cycle 6, DONE after cycle 9, `timeout`=0.
- Last halt and budget hit together (limit=10, `halt_f` at cycle 10) → `timeout`=0.
- `err_bits`=2'b01 pulsed for 1 cycle at cycle 4:
  - Without the macro: `err_latched`=01, run completes normally.
  - With the macro: DONE at cycle 5, `err_stop`=1.
- `rst` asserted mid-RUN at cycle 7 → all outputs return to reset values without waiting for a clock edge. A following `start` clears all status and reruns cleanly.
